// File: rtl/tc_timer_pkg.sv
// rtl/tc_timer_pkg.sv - shared register map, mode and FSM encodings for tc_timer
//
// Purpose: single source for the timer's register offsets, CTRL field layout,
// MODE encodings, countdown FSM state encoding and the bus base addresses of
// the two timer instances placed by the system bridge.
// Ports: none (package).

package tc_timer_pkg;

  // Word offsets within a timer window (bus address bits [3:2]).
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL.MODE encodings; 2'b1x behaves like one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Base addresses of the two timer windows.
  localparam logic [31:0] TC_TIMER0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TC_TIMER1_BASE = 32'h0000_7f10;

  // Countdown FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Stored CTRL bits, packed in register bit order ([3]=IM, [2:1]=MODE, [0]=EN).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Only the exact auto-reload encoding reloads; every other value is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped countdown timer with level interrupt request
//
// Purpose: word-addressed timer holding CTRL, PRESET and COUNT registers, a
// four-state countdown FSM (IDLE/LOAD/CNT/INT) and a level irq for CP0.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; clears all state
//   addr   - word offset within the window (bus addr[3:2])
//   we     - write strobe, sampled at rising clk edge
//   din    - write data
//   dout   - read data, combinational from addr
//   irq    - interrupt request (int_flag & CTRL.IM)

module tc_timer
  import tc_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  tc_state_e        state_q, state_d;
  tc_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             int_flag_q, int_flag_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      int_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
    end
  end

  // FSM update first, bus write applied afterwards so a same-edge write wins.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          // Pause: COUNT frozen; re-enable goes through LOAD again.
          state_d = ST_IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          // COUNT<=1 also covers PRESET=0, so COUNT never wraps.
          count_d    = '0;
          state_d    = ST_INT;
          int_flag_d = 1'b1;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q.mode)) begin
          int_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (we) begin
      case (addr)
        OFF_CTRL: begin
          ctrl_d     = tc_ctrl_t'(din[3:0]);
          int_flag_d = 1'b0;
        end
        OFF_PRESET: begin
          preset_d = din;
        end
        default: begin
          // COUNT is read-only and offset 3 is reserved.
        end
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      OFF_CTRL:   dout = {{(WIDTH-4){1'b0}}, ctrl_q};
      OFF_PRESET: dout = preset_q;
      OFF_COUNT:  dout = count_q;
      OFF_RSVD:   dout = '0;
      default:    dout = '0;
    endcase
  end

  // Registered sources only, so din cannot glitch the interrupt line.
  assign irq = int_flag_q & ctrl_q.im;

endmodule
